// File: rtl/uart_defs.sv
// Shared definitions for the UART register block: register map, status bits,
// version, mode configuration and the AXI channel payload types.
package uart_defs;

    localparam logic [11:0] OFF_DIVIDER   = 12'h000;
    localparam logic [11:0] OFF_TXDATA    = 12'h004;
    localparam logic [11:0] OFF_RXDATA    = 12'h008;
    localparam logic [11:0] OFF_STATUS    = 12'h00C;
    localparam logic [11:0] OFF_IRQMASK   = 12'h010;
    localparam logic [11:0] OFF_CONFIG    = 12'h014;
    localparam logic [11:0] OFF_WATERMARK = 12'h018;
    localparam logic [11:0] OFF_LEVEL     = 12'h01C;
    localparam logic [11:0] OFF_VERSION   = 12'h020;

    localparam int ST_TX_EMPTY    = 0;
    localparam int ST_TX_BELOW_WM = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_ABOVE_WM = 3;
    localparam int ST_RX_OVERRUN  = 4;

    localparam logic [7:0]  VER_MAJOR   = 8'd2;
    localparam logic [7:0]  VER_MINOR   = 8'd1;
    localparam logic [15:0] VER_PATCHES = 16'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AXI_ID_W = 4;

    typedef struct packed {
        logic rx_en;
        logic tx_en;
        logic stop2;
        logic parity_odd;
        logic parity_en;
    } Config_t;

    typedef enum logic [1:0] {IDLE, RRESP, BRESP} State_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [31:0]         addr;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [31:0]         data;
        logic [1:0]          resp;
        logic                last;
    } axi_r_t;

    function automatic logic reg_valid(input logic [11:0] off);
        case (off)
            OFF_DIVIDER, OFF_TXDATA, OFF_RXDATA, OFF_STATUS, OFF_IRQMASK,
            OFF_CONFIG, OFF_WATERMARK, OFF_LEVEL, OFF_VERSION: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi4_if.sv
// Single-beat AXI4 register bus: five valid/ready channels with struct payloads.
interface axi4;
    import uart_defs::*;

    logic    aw_valid, aw_ready;
    axi_ax_t aw;
    logic    w_valid, w_ready;
    axi_w_t  w;
    logic    b_valid, b_ready;
    axi_b_t  b;
    logic    ar_valid, ar_ready;
    axi_ax_t ar;
    logic    r_valid, r_ready;
    axi_r_t  r;

    modport slave (
        input  aw_valid, aw, w_valid, w, b_ready, ar_valid, ar, r_ready,
        output aw_ready, w_ready, b_valid, b, ar_ready, r_valid, r
    );

    modport master (
        output aw_valid, aw, w_valid, w, b_ready, ar_valid, ar, r_ready,
        input  aw_ready, w_ready, b_valid, b, ar_ready, r_valid, r
    );
endinterface

// File: rtl/uart_csr_fifo.sv
// Power-of-two synchronous FIFO; a push while full is accepted only when a pop
// frees the head slot in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_csr.sv
// AXI4 register slave for the UART core: baud/config registers, TX/RX byte
// FIFOs, sticky RX overrun and masked, registered interrupt.
module uart_csr
    import uart_defs::*;
#(
    parameter logic [31:0] REGMAP    = 32'h0,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter int          DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4.slave                   bus,
    output logic [DIV_WIDTH-1:0] uart_divider,
    output Config_t              uart_config,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_ready,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_valid,
    output logic                 irq
);
    localparam int TCW   = $clog2(TX_DEPTH) + 1;
    localparam int RCW   = $clog2(RX_DEPTH) + 1;
    localparam int CFG_W = $bits(Config_t);

    State_t              state_q, state_d;
    logic [DIV_WIDTH-1:0] divider_q, divider_d;
    Config_t             config_q, config_d;
    logic [4:0]          irqmask_q, irqmask_d;
    logic [7:0]          tx_wm_q, tx_wm_d, rx_wm_q, rx_wm_d;
    logic                overrun_q, overrun_d;
    logic                irq_q, irq_d;
    logic [AXI_ID_W-1:0] b_id_q, b_id_d, r_id_q, r_id_d;
    logic [1:0]          b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [31:0]         r_data_q, r_data_d;

    logic                wr_hs, rd_hs, wr_hit, rd_hit;
    logic                tx_push, tx_full, tx_empty;
    logic                rx_pop, rx_full, rx_empty, rx_overrun;
    logic [TCW-1:0]      tx_count;
    logic [RCW-1:0]      rx_count;
    logic [7:0]          rx_dout, rx_wm_eff;
    logic [4:0]          status;
    logic                unused_wdata;

    assign unused_wdata = ^bus.w.data;

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(uart_tx_ready),
        .din(bus.w.data[7:0]), .dout(uart_tx_data),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(uart_rx_valid), .pop(rx_pop),
        .din(uart_rx_data), .dout(rx_dout),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // A pop in the same cycle makes room, so only an unmatched full push overruns.
    assign rx_overrun = uart_rx_valid && rx_full && !rx_pop;
    assign rx_wm_eff  = (rx_wm_q == 8'd0) ? 8'd1 : rx_wm_q;

    always_comb begin
        status                 = '0;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_BELOW_WM] = 8'(tx_count) < tx_wm_q;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_RX_ABOVE_WM] = 8'(rx_count) >= rx_wm_eff;
        status[ST_RX_OVERRUN]  = overrun_q;
    end

    assign irq_d  = |(status & irqmask_q);
    assign wr_hit = (bus.aw.addr[31:12] == REGMAP[31:12]) && reg_valid(bus.aw.addr[11:0]);
    assign rd_hit = (bus.ar.addr[31:12] == REGMAP[31:12]) && reg_valid(bus.ar.addr[11:0]);

    always_comb begin
        state_d      = state_q;
        wr_hs        = 1'b0;
        rd_hs        = 1'b0;
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        bus.ar_ready = 1'b0;
        bus.b_valid  = 1'b0;
        bus.b        = '0;
        bus.r_valid  = 1'b0;
        bus.r        = '0;
        case (state_q)
            IDLE: begin
                if (bus.aw_valid && bus.w_valid) begin
                    bus.aw_ready = 1'b1;
                    bus.w_ready  = 1'b1;
                    wr_hs        = 1'b1;
                    state_d      = BRESP;
                end else if (bus.ar_valid) begin
                    bus.ar_ready = 1'b1;
                    rd_hs        = 1'b1;
                    state_d      = RRESP;
                end
            end
            BRESP: begin
                bus.b_valid = 1'b1;
                bus.b.id    = b_id_q;
                bus.b.resp  = b_resp_q;
                if (bus.b_ready) state_d = IDLE;
            end
            RRESP: begin
                bus.r_valid = 1'b1;
                bus.r.last  = 1'b1;
                bus.r.id    = r_id_q;
                bus.r.data  = r_data_q;
                bus.r.resp  = r_resp_q;
                if (bus.r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        divider_d = divider_q;
        config_d  = config_q;
        irqmask_d = irqmask_q;
        tx_wm_d   = tx_wm_q;
        rx_wm_d   = rx_wm_q;
        overrun_d = overrun_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;
        r_id_d    = r_id_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        if (wr_hs) begin
            b_id_d   = bus.aw.id;
            b_resp_d = wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_hit) begin
                case (bus.aw.addr[11:0])
                    OFF_DIVIDER: divider_d = bus.w.data[DIV_WIDTH-1:0];
                    OFF_TXDATA: begin
                        if (tx_full) b_resp_d = RESP_SLVERR;
                        else         tx_push  = 1'b1;
                    end
                    OFF_STATUS:  if (bus.w.data[ST_RX_OVERRUN]) overrun_d = 1'b0;
                    OFF_IRQMASK: irqmask_d = bus.w.data[4:0];
                    OFF_CONFIG:  config_d = Config_t'(bus.w.data[CFG_W-1:0]);
                    OFF_WATERMARK: begin
                        rx_wm_d = bus.w.data[23:16];
                        tx_wm_d = bus.w.data[7:0];
                    end
                    default: ;
                endcase
            end
        end
        if (rd_hs) begin
            r_id_d   = bus.ar.id;
            r_resp_d = rd_hit ? RESP_OKAY : RESP_SLVERR;
            r_data_d = '0;
            if (rd_hit) begin
                case (bus.ar.addr[11:0])
                    OFF_DIVIDER:   r_data_d = 32'(divider_q);
                    OFF_RXDATA: begin
                        if (rx_empty) r_data_d = 32'h8000_0000;
                        else begin
                            r_data_d = {24'b0, rx_dout};
                            rx_pop   = 1'b1;
                        end
                    end
                    OFF_STATUS:    r_data_d = {27'b0, status};
                    OFF_IRQMASK:   r_data_d = {27'b0, irqmask_q};
                    OFF_CONFIG:    r_data_d = {{(32-CFG_W){1'b0}}, config_q};
                    OFF_WATERMARK: r_data_d = {8'b0, rx_wm_q, 8'b0, tx_wm_q};
                    OFF_LEVEL:     r_data_d = {8'b0, 8'(rx_count), 8'b0, 8'(tx_count)};
                    OFF_VERSION:   r_data_d = {VER_MAJOR, VER_MINOR, VER_PATCHES};
                    default: ;
                endcase
            end
        end
        // A same-cycle overrun beats the W1C clear.
        if (rx_overrun) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            divider_q <= '0;
            config_q  <= '0;
            irqmask_q <= '0;
            tx_wm_q   <= '0;
            rx_wm_q   <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= '0;
            r_id_q    <= '0;
            r_resp_q  <= '0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            divider_q <= divider_d;
            config_q  <= config_d;
            irqmask_q <= irqmask_d;
            tx_wm_q   <= tx_wm_d;
            rx_wm_q   <= rx_wm_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
            r_id_q    <= r_id_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    assign uart_divider  = divider_q;
    assign uart_config   = config_q;
    assign uart_tx_valid = !tx_empty;
    assign irq           = irq_q;

endmodule

// File: tb/tb_uart_csr.sv
// Directed scoreboard bench for uart_csr: expected bus responses are queued as
// each transaction is issued and checked when the response channel fires.
module tb_uart_csr;
    import uart_defs::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic [15:0] uart_divider;
    Config_t    uart_config;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid, uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       irq;

    always #5 clk = ~clk;

    axi4 bus();

    uart_csr #(.REGMAP(BASE), .TX_DEPTH(16), .RX_DEPTH(16), .DIV_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .uart_divider(uart_divider), .uart_config(uart_config),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .irq(irq)
    );

    typedef struct {
        string               tag;
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
        logic [31:0]         data;
    } exp_t;

    exp_t                sb[$];
    int                  total = 0;
    int                  bad   = 0;
    logic [AXI_ID_W-1:0] next_id = '0;

    function automatic logic [31:0] a(input logic [11:0] off);
        return BASE + {20'b0, off};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    task automatic expect_rsp(input string tag, input logic [AXI_ID_W-1:0] id,
                              input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        e.tag  = tag;
        e.id   = id;
        e.resp = resp;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic send_w(input logic [31:0] addr, input logic [31:0] data,
                          input logic [AXI_ID_W-1:0] id);
        int n;
        bus.aw_valid = 1'b1;
        bus.aw.addr  = addr;
        bus.aw.id    = id;
        bus.w_valid  = 1'b1;
        bus.w.data   = data;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.aw_ready && bus.w_ready) break;
        end
        if (n == 20) timeout("aw_ready");
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [AXI_ID_W-1:0] id);
        int n;
        bus.ar_valid = 1'b1;
        bus.ar.addr  = addr;
        bus.ar.id    = id;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.ar_ready) break;
        end
        if (n == 20) timeout("ar_ready");
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic wait_b();
        int   n;
        exp_t e;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.b_valid) break;
        end
        if (sb.size() == 0) begin
            timeout("scoreboard_empty_b");
            return;
        end
        e = sb.pop_front();
        if (n == 20) begin
            timeout({e.tag, "_bvalid"});
            return;
        end
        check({e.tag, "_bresp"}, 32'(bus.b.resp), 32'(e.resp));
        check({e.tag, "_bid"}, 32'(bus.b.id), 32'(e.id));
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        int   n;
        exp_t e;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.r_valid) break;
        end
        if (sb.size() == 0) begin
            timeout("scoreboard_empty_r");
            return;
        end
        e = sb.pop_front();
        if (n == 20) begin
            timeout({e.tag, "_rvalid"});
            return;
        end
        check({e.tag, "_rresp"}, 32'(bus.r.resp), 32'(e.resp));
        check({e.tag, "_rdata"}, bus.r.data, e.data);
        check({e.tag, "_rid"}, 32'(bus.r.id), 32'(e.id));
        check({e.tag, "_rlast"}, 32'(bus.r.last), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [1:0] resp);
        logic [AXI_ID_W-1:0] id;
        id = next_id;
        next_id = next_id + 1'b1;
        expect_rsp(tag, id, resp, 32'h0);
        send_w(addr, data, id);
        wait_b();
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] resp);
        logic [AXI_ID_W-1:0] id;
        id = next_id;
        next_id = next_id + 1'b1;
        expect_rsp(tag, id, resp, data);
        send_ar(addr, id);
        wait_r();
    endtask

    initial begin
        logic [AXI_ID_W-1:0] idw, idr;
        rst = 1'b1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
        bus.b_ready = 1'b1;  bus.r_ready = 1'b1;
        bus.aw = '0; bus.w = '0; bus.ar = '0;
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_div", 32'(uart_divider), 32'h0);
        check("rst_cfg", {27'b0, uart_config}, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_txvalid", 32'(uart_tx_valid), 32'h0);
        check("rst_txdata", 32'(uart_tx_data), 32'h0);
        check("rst_bvalid", 32'(bus.b_valid), 32'h0);
        check("rst_rvalid", 32'(bus.r_valid), 32'h0);
        check("rst_awready", 32'(bus.aw_ready), 32'h0);

        // Reset in the middle of BRESP drops the response and clears registers.
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        send_w(a(OFF_DIVIDER), 32'h0000_0055, 4'h7);
        @(negedge clk);
        check("midb_bvalid", 32'(bus.b_valid), 32'h1);
        check("midb_div", 32'(uart_divider), 32'h55);
        rst = 1'b1;
        #1;
        check("midb_bvalid_drop", 32'(bus.b_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.b_ready = 1'b1;
        axi_read("rst_rd_div",   a(OFF_DIVIDER),   32'h0, RESP_OKAY);
        axi_read("rst_rd_cfg",   a(OFF_CONFIG),    32'h0, RESP_OKAY);
        axi_read("rst_rd_mask",  a(OFF_IRQMASK),   32'h0, RESP_OKAY);
        axi_read("rst_rd_wm",    a(OFF_WATERMARK), 32'h0, RESP_OKAY);
        axi_read("rst_rd_stat",  a(OFF_STATUS),    32'h0000_0001, RESP_OKAY);
        axi_read("rst_rd_level", a(OFF_LEVEL),     32'h0, RESP_OKAY);
        axi_read("rst_rd_rx",    a(OFF_RXDATA),    32'h8000_0000, RESP_OKAY);
        axi_read("rd_version",   a(OFF_VERSION),   32'h0201_0003, RESP_OKAY);

        axi_write("wr_div", a(OFF_DIVIDER), 32'h0000_1458, RESP_OKAY);
        axi_read("rd_div", a(OFF_DIVIDER), 32'h0000_1458, RESP_OKAY);
        check("div_out", 32'(uart_divider), 32'h0000_1458);

        // Fill TX with the engine stalled; the 17th byte must be refused.
        for (int i = 0; i < 17; i++)
            axi_write($sformatf("tx_wr%0d", i), a(OFF_TXDATA), 32'hA0 + i,
                      (i < 16) ? RESP_OKAY : RESP_SLVERR);
        axi_read("tx_level", a(OFF_LEVEL), 32'h0000_0010, RESP_OKAY);
        check("tx_valid_full", 32'(uart_tx_valid), 32'h1);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("tx_out%0d", i), {uart_tx_valid, 23'b0, uart_tx_data}, 32'h8000_00A0 + i);
        end
        @(negedge clk);
        check("tx_drained", 32'(uart_tx_valid), 32'h0);
        uart_tx_ready = 1'b0;
        @(posedge clk); #1;

        // RX overrun: 17 pushes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'h30 + 8'(i);
            @(posedge clk); #1;
        end
        uart_rx_valid = 1'b0;
        axi_read("rx_stat_ovr", a(OFF_STATUS), 32'h0000_001D, RESP_OKAY);
        check("irq_masked", 32'(irq), 32'h0);
        axi_write("wr_mask", a(OFF_IRQMASK), 32'h0000_0010, RESP_OKAY);
        check("irq_ovr", 32'(irq), 32'h1);
        axi_read("rd_mask", a(OFF_IRQMASK), 32'h0000_0010, RESP_OKAY);
        axi_write("w1c_ovr", a(OFF_STATUS), 32'h0000_0010, RESP_OKAY);
        check("irq_cleared", 32'(irq), 32'h0);
        axi_read("rx_stat_clr", a(OFF_STATUS), 32'h0000_000D, RESP_OKAY);

        // Watermark boundaries: rx_wm one above and equal to the count.
        axi_write("wr_wm17", a(OFF_WATERMARK), 32'h0011_0003, RESP_OKAY);
        axi_read("stat_wm17", a(OFF_STATUS), 32'h0000_0007, RESP_OKAY);
        axi_write("wr_wm16", a(OFF_WATERMARK), 32'h0010_0000, RESP_OKAY);
        axi_read("stat_wm16", a(OFF_STATUS), 32'h0000_000D, RESP_OKAY);
        axi_read("rd_wm", a(OFF_WATERMARK), 32'h0010_0000, RESP_OKAY);
        axi_write("wr_wm0", a(OFF_WATERMARK), 32'h0, RESP_OKAY);

        // Push and pop on the same edge while full: no overrun, count held.
        idr = next_id;
        next_id = next_id + 1'b1;
        expect_rsp("rx_simul", idr, RESP_OKAY, 32'h0000_0030);
        bus.ar_valid = 1'b1;
        bus.ar.addr  = a(OFF_RXDATA);
        bus.ar.id    = idr;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        @(negedge clk);
        check("simul_arready", 32'(bus.ar_ready), 32'h1);
        @(posedge clk); #1;
        bus.ar_valid  = 1'b0;
        uart_rx_valid = 1'b0;
        wait_r();
        axi_read("simul_level", a(OFF_LEVEL), 32'h0010_0000, RESP_OKAY);
        axi_read("simul_stat", a(OFF_STATUS), 32'h0000_000D, RESP_OKAY);
        check("simul_irq", 32'(irq), 32'h0);
        for (int i = 1; i < 16; i++)
            axi_read($sformatf("rx_pop%0d", i), a(OFF_RXDATA), 32'h30 + i, RESP_OKAY);
        axi_read("rx_pop_last", a(OFF_RXDATA), 32'h0000_0077, RESP_OKAY);
        axi_read("rx_pop_empty", a(OFF_RXDATA), 32'h8000_0000, RESP_OKAY);
        axi_read("stat_idle", a(OFF_STATUS), 32'h0000_0001, RESP_OKAY);

        // Write and read offered together: write first, read sees new value.
        idw = next_id;
        idr = next_id + 1'b1;
        next_id = next_id + 2'd2;
        expect_rsp("both_wr", idw, RESP_OKAY, 32'h0);
        expect_rsp("both_rd", idr, RESP_OKAY, 32'h0000_0015);
        bus.aw_valid = 1'b1; bus.aw.addr = a(OFF_CONFIG); bus.aw.id = idw;
        bus.w_valid  = 1'b1; bus.w.data  = 32'h0000_0015;
        bus.ar_valid = 1'b1; bus.ar.addr = a(OFF_CONFIG); bus.ar.id = idr;
        @(negedge clk);
        check("both_awready", 32'(bus.aw_ready), 32'h1);
        check("both_arready", 32'(bus.ar_ready), 32'h0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        wait_b();
        send_ar(a(OFF_CONFIG), idr);
        wait_r();
        check("cfg_out", {27'b0, uart_config}, 32'h0000_0015);

        // Decode errors leave state untouched.
        axi_read("rd_bad_off", a(12'h040), 32'h0, RESP_SLVERR);
        axi_write("wr_bad_base", a(OFF_DIVIDER) + 32'h1000, 32'h0000_BEEF, RESP_SLVERR);
        axi_read("div_kept", a(OFF_DIVIDER), 32'h0000_1458, RESP_OKAY);
        check("div_out_kept", 32'(uart_divider), 32'h0000_1458);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_csr.md
# uart_csr

Parametrised AXI4 register slave for the UART core, the next generation of the UART register block. It adds configurable-depth TX and RX data FIFOs, a sticky RX overrun flag, watermark-based interrupt generation and fully registered AXI responses. It sits between the system AXI4 interconnect and the UART TX/RX shift engines, which exchange bytes with it over valid/ready streams.

## Interface

- REGMAP, 32'h0: 4 KiB-aligned base address; bits [31:12] are compared.
- TX_DEPTH, 16: TX FIFO entries, power of two, at least 2.
- RX_DEPTH, 16: RX FIFO entries, power of two, at least 2.
- DIV_WIDTH, 16: baud divider width, at most 32; divider = f_clk / baud.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- bus  axi4.slave  -  register bus. Single beat only; at most one outstanding transaction.
- uart_divider  out  DIV_WIDTH  baud divider.
- uart_config  out  Config_t  mode bits (parity, stop bits, enables).
- uart_tx_data / uart_tx_valid  out  8 / 1  head of the TX FIFO.
- uart_tx_ready  in  1  the TX engine pops the head when valid and ready are both high.
- uart_rx_data / uart_rx_valid  in  8 / 1  a received byte; pushed into the RX FIFO.
- irq  out  1  level interrupt.

## Operation

Register offsets:
- 0x00 DIVIDER: RW.
- 0x04 TXDATA: WO. A write pushes data[7:0]. If the FIFO is full the byte is dropped and the response is SLVERR.
- 0x08 RXDATA: RO. A read pops the FIFO and returns {bit31=0, 23'b0, byte}. If the FIFO is empty the read returns 32'h8000_0000, with no pop and resp OKAY.
- 0x0C STATUS: bits {4 rx_overrun (W1C), 3 rx_above_wm, 2 rx_nonempty, 1 tx_below_wm, 0 tx_empty}. All other bits are read-only.
- 0x10 IRQMASK: RW [4:0].
- 0x14 CONFIG: RW Config_t.
- 0x18 WATERMARK: RW {rx_wm[23:16], tx_wm[7:0]}.
- 0x1C LEVEL: RO {rx_count[23:16], tx_count[7:0]}.
- 0x20 VERSION: RO {MAJOR, MINOR, PATCHES}.
- Any other offset, or an address outside REGMAP: SLVERR, with no side effects and read data 0.

Status and interrupt rules:
- tx_below_wm = tx_count < tx_wm.
- rx_above_wm = rx_count >= rx_wm, with rx_wm = 0 treated as 1.
- irq = |(STATUS[4:0] & IRQMASK[4:0]).

Bus state machine:
- IDLE: if aw_valid && w_valid, assert aw_ready and w_ready combinationally, perform the write, go to BRESP. Otherwise, if ar_valid, assert ar_ready, capture read data and resp, go to RRESP. Writes win when both are pending.
- BRESP: b_valid=1; b.id is the captured aw.id; b.resp is the captured resp. Go to IDLE on b_ready.
- RRESP: r_valid=1, r.last=1; r.data, r.resp and r.id (the captured ar.id) come from registers. Go to IDLE on r_ready.
- All bus outputs are driven in every state (default 0); no latches.

FIFO rules:
- A push when full is dropped; for RX this also sets rx_overrun.
- A push and a pop in the same cycle are both performed and the count is unchanged. For RX this holds even when the FIFO is full.
- Pointers wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide, zero-extended into LEVEL.
- If an RX overrun and a W1C write of rx_overrun happen in the same cycle, the set wins.

## Timing

- Register write and FIFO push take effect at the AW/W handshake edge. b_valid rises the next cycle, so write latency is 1 cycle.
- Read data is sampled and the RXDATA pop happens at the AR handshake edge. r_valid rises the next cycle.
- Earliest back-to-back transaction: one every 2 cycles.
- irq is registered, 1 cycle after the status change.
- uart_tx_valid = !tx_empty, driven combinationally from the FIFO.
- Reset values:
  - all FIFOs empty, state IDLE, all valid/ready outputs 0;
  - uart_divider 0, uart_config 0, IRQMASK 0, WATERMARK 0, overrun 0, irq 0;
  - uart_tx_data 0.
- Reset mid-transaction aborts the transaction with no response and flushes the FIFOs.

## Structure

- Add to uart_defs: the offsets above, STATUS bit indices, VERSION constants, Config_t, and State_t {IDLE, RRESP, BRESP}.
- Sub-module uart_fifo #(WIDTH, DEPTH), instantiated once for TX and once for RX. Ports: push, pop, din, dout, full, empty, count.

## Test plan

- Reset mid-BRESP: b_valid drops immediately and all registers read back their reset values afterwards.
- Write DIVIDER = 0x1458, then read it: resp OKAY, data 0x0000_1458, uart_divider = 16'h1458.
- TX_DEPTH=16 with uart_tx_ready=0: 17 TXDATA writes. Writes 1–16 return OKAY and write 17 returns SLVERR; LEVEL[7:0] = 16. Raise ready: the bytes emerge in order.
- RX_DEPTH=16: push 17 bytes. STATUS bit4 = 1. With IRQMASK = 0x10, irq = 1. W1C 0x10 clears both. The first 16 bytes pop in order; the next read returns 0x8000_0000.
- Simultaneous RX push and RXDATA pop with the FIFO full: count stays 16 and no overrun is flagged. Simultaneous aw+ar: the write is served first, then the read.
- A read at offset 0x40 and a write to base+0x1000 both return SLVERR with no state change.
